// File: rtl/uart_rx_frame_ctrl.sv
// UART receive-path controller: owns receiver enable and baud selection, and parses
// SYNC/LEN/payload/CHK frames into a payload buffer with accept/reject pulses.
module uart_rx_frame_ctrl #(
   parameter int                    DATA_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
   parameter int                    MAX_LEN        = 16,
   parameter int                    ADDR_WIDTH     = 4,
   parameter int                    TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_arst_n,
   input  logic                  i_ctrl_en,
   input  logic [3:0]            i_cfg_baud_sel,
   input  logic                  i_cfg_load,
   input  logic                  i_rx_done,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   output logic                  o_rx_enable,
   output logic [3:0]            o_baud_sel,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   output logic                  o_pkt_valid,
   output logic [ADDR_WIDTH:0]   o_pkt_len,
   output logic                  o_pkt_error,
   output logic [1:0]            o_err_code,
   output logic                  o_busy
);

   localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CHK  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SYNC,
      S_GET_LEN,
      S_GET_DATA,
      S_GET_CHK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_idx;
   logic [DATA_WIDTH-1:0] r_chk;
   logic [TMO_W-1:0]      r_tmo;

   logic                  r_rx_enable;
   logic [3:0]            r_baud_sel;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_pkt_valid;
   logic [ADDR_WIDTH:0]   r_pkt_len;
   logic                  r_pkt_error;
   logic [1:0]            r_err_code;
   logic                  r_busy;

   logic                  w_len_ok;
   logic                  w_tmo_hit;
   logic                  w_last_byte;
   logic                  w_cfg_window;

   assign w_len_ok     = (i_rx_data != '0) && (i_rx_data <= DATA_WIDTH'(MAX_LEN));
   assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_last_byte  = ((r_idx + (ADDR_WIDTH+1)'(1)) == r_len);
   assign w_cfg_window = (r_state == S_IDLE) || (r_state == S_WAIT_SYNC);

   // Pulses default low each cycle; an rx_done in the same cycle as a timeout takes priority.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_idx       <= '0;
         r_chk       <= '0;
         r_tmo       <= '0;
         r_rx_enable <= 1'b0;
         r_baud_sel  <= 4'b0011;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_pkt_valid <= 1'b0;
         r_pkt_len   <= '0;
         r_pkt_error <= 1'b0;
         r_err_code  <= 2'b00;
         r_busy      <= 1'b0;
      end else begin
         r_rx_enable <= i_ctrl_en;
         r_mem_we    <= 1'b0;
         r_pkt_valid <= 1'b0;
         r_pkt_error <= 1'b0;

         if (i_cfg_load && w_cfg_window) begin
            r_baud_sel <= i_cfg_baud_sel;
         end

         if (!i_ctrl_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_WAIT_SYNC;
               end

               S_WAIT_SYNC: begin
                  if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
                     r_state <= S_GET_LEN;
                     r_busy  <= 1'b1;
                     r_tmo   <= '0;
                  end
               end

               S_GET_LEN: begin
                  if (i_rx_done) begin
                     r_tmo <= '0;
                     if (w_len_ok) begin
                        r_len   <= (ADDR_WIDTH+1)'(i_rx_data);
                        r_chk   <= i_rx_data;
                        r_idx   <= '0;
                        r_state <= S_GET_DATA;
                     end else begin
                        r_state     <= S_ERROR;
                        r_pkt_error <= 1'b1;
                        r_err_code  <= ERR_LEN;
                        r_busy      <= 1'b0;
                     end
                  end else if (w_tmo_hit) begin
                     r_state     <= S_ERROR;
                     r_pkt_error <= 1'b1;
                     r_err_code  <= ERR_TMO;
                     r_busy      <= 1'b0;
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end

               S_GET_DATA: begin
                  if (i_rx_done) begin
                     r_tmo       <= '0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_idx[ADDR_WIDTH-1:0];
                     r_mem_wdata <= i_rx_data;
                     r_chk       <= r_chk ^ i_rx_data;
                     r_idx       <= r_idx + (ADDR_WIDTH+1)'(1);
                     if (w_last_byte) begin
                        r_state <= S_GET_CHK;
                     end
                  end else if (w_tmo_hit) begin
                     r_state     <= S_ERROR;
                     r_pkt_error <= 1'b1;
                     r_err_code  <= ERR_TMO;
                     r_busy      <= 1'b0;
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end

               S_GET_CHK: begin
                  if (i_rx_done) begin
                     r_tmo  <= '0;
                     r_busy <= 1'b0;
                     if (i_rx_data == r_chk) begin
                        r_state     <= S_DONE;
                        r_pkt_valid <= 1'b1;
                        r_pkt_len   <= r_len;
                     end else begin
                        r_state     <= S_ERROR;
                        r_pkt_error <= 1'b1;
                        r_err_code  <= ERR_CHK;
                     end
                  end else if (w_tmo_hit) begin
                     r_state     <= S_ERROR;
                     r_pkt_error <= 1'b1;
                     r_err_code  <= ERR_TMO;
                     r_busy      <= 1'b0;
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end

               S_DONE: begin
                  r_state <= S_WAIT_SYNC;
               end

               S_ERROR: begin
                  r_state <= S_WAIT_SYNC;
               end

               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_rx_enable = r_rx_enable;
   assign o_baud_sel  = r_baud_sel;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_pkt_valid = r_pkt_valid;
   assign o_pkt_len   = r_pkt_len;
   assign o_pkt_error = r_pkt_error;
   assign o_err_code  = r_err_code;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random frames scored against a
// byte-stream frame parser model, plus timeout, baud, reset and enable scenarios.
module tb_uart_rx_frame_ctrl;

   typedef logic [7:0] byteQ_t [$];

   localparam int MAX_LEN = 16;
   localparam int TMO     = 100;

   logic       clk        = 1'b0;
   logic       arstN      = 1'b0;
   logic       ctrlEn     = 1'b0;
   logic [3:0] cfgBaudSel = 4'h0;
   logic       cfgLoad    = 1'b0;
   logic       rxDone     = 1'b0;
   logic [7:0] rxData     = 8'h00;

   logic       rxEnable;
   logic [3:0] baudSel;
   logic       memWe;
   logic [3:0] memAddr;
   logic [7:0] memWdata;
   logic       pktValid;
   logic [4:0] pktLen;
   logic       pktError;
   logic [1:0] errCode;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lastDrv  = 0;

   int wrAddrQ[$];
   int wrDataQ[$];
   int wrLatQ[$];
   int valLenQ[$];
   int errCodeQ[$];
   int errCycQ[$];

   uart_rx_frame_ctrl #(
      .DATA_WIDTH     (8),
      .SYNC_BYTE      (8'hA5),
      .MAX_LEN        (MAX_LEN),
      .ADDR_WIDTH     (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk          (clk),
      .i_arst_n       (arstN),
      .i_ctrl_en      (ctrlEn),
      .i_cfg_baud_sel (cfgBaudSel),
      .i_cfg_load     (cfgLoad),
      .i_rx_done      (rxDone),
      .i_rx_data      (rxData),
      .o_rx_enable    (rxEnable),
      .o_baud_sel     (baudSel),
      .o_mem_we       (memWe),
      .o_mem_addr     (memAddr),
      .o_mem_wdata    (memWdata),
      .o_pkt_valid    (pktValid),
      .o_pkt_len      (pktLen),
      .o_pkt_error    (pktError),
      .o_err_code     (errCode),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard capture of every buffer write and result pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (memWe) begin
         wrAddrQ.push_back(int'(memAddr));
         wrDataQ.push_back(int'(memWdata));
         wrLatQ.push_back(cyc - lastDrv);
      end
      if (pktValid) valLenQ.push_back(int'(pktLen));
      if (pktError) begin
         errCodeQ.push_back(int'(errCode));
         errCycQ.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearSb();
      wrAddrQ.delete();
      wrDataQ.delete();
      wrLatQ.delete();
      valLenQ.delete();
      errCodeQ.delete();
      errCycQ.delete();
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      rxDone  = 1'b1;
      rxData  = b;
      lastDrv = cyc;
      @(negedge clk);
      rxDone  = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
   endtask

   task automatic sendFrame(input byteQ_t f);
      foreach (f[i]) applyStimulus(f[i]);
   endtask

   // Frame parser over a raw byte stream: kind 0 = incomplete, 1 = accepted, 2 = rejected.
   task automatic modelFrame(input byteQ_t f, output byteQ_t wr, output int kind,
                             output int len, output logic [1:0] code);
      int p;
      logic [7:0] x;
      wr   = {};
      kind = 0;
      len  = 0;
      code = 2'b00;
      p    = 0;
      while (p < f.size() && f[p] != 8'hA5) p++;
      p++;
      if (p >= f.size()) return;
      len = int'(f[p]);
      p++;
      if (len == 0 || len > MAX_LEN) begin
         kind = 2;
         code = 2'b01;
         return;
      end
      x = f[p-1];
      for (int i = 0; i < len && p < f.size(); i++) begin
         wr.push_back(f[p]);
         x = x ^ f[p];
         p++;
      end
      if (p >= f.size()) return;
      if (f[p] == x) begin
         kind = 1;
      end else begin
         kind = 2;
         code = 2'b10;
      end
   endtask

   task automatic checkFrame(input string tag, input byteQ_t f);
      byteQ_t     expWr;
      int         kind;
      int         expLen;
      logic [1:0] expCode;
      modelFrame(f, expWr, kind, expLen, expCode);
      repeat (3) @(negedge clk);
      #1;
      checkOutput({tag, ".nwrites"}, wrDataQ.size(), expWr.size());
      foreach (expWr[i]) begin
         if (i < wrDataQ.size()) begin
            checkOutput({tag, ".addr"}, wrAddrQ[i], i);
            checkOutput({tag, ".data"}, wrDataQ[i], expWr[i]);
            checkOutput({tag, ".latency"}, wrLatQ[i], 1);
         end
      end
      checkOutput({tag, ".nvalid"}, valLenQ.size(), (kind == 1) ? 1 : 0);
      checkOutput({tag, ".nerror"}, errCodeQ.size(), (kind == 2) ? 1 : 0);
      if (kind == 1 && valLenQ.size() > 0) begin
         checkOutput({tag, ".len"}, valLenQ[0], expLen);
         checkOutput({tag, ".lenHeld"}, pktLen, expLen);
      end
      if (kind == 2 && errCodeQ.size() > 0) begin
         checkOutput({tag, ".code"}, errCodeQ[0], expCode);
         checkOutput({tag, ".codeHeld"}, errCode, expCode);
      end
      checkOutput({tag, ".busyIdle"}, busy, 1'b0);
      clearSb();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".rxEnable"}, rxEnable, 1'b0);
      checkOutput({tag, ".baudSel"}, baudSel, 4'b0011);
      checkOutput({tag, ".memWe"}, memWe, 1'b0);
      checkOutput({tag, ".memAddr"}, memAddr, 4'h0);
      checkOutput({tag, ".memWdata"}, memWdata, 8'h00);
      checkOutput({tag, ".pktValid"}, pktValid, 1'b0);
      checkOutput({tag, ".pktLen"}, pktLen, 5'h0);
      checkOutput({tag, ".pktError"}, pktError, 1'b0);
      checkOutput({tag, ".errCode"}, errCode, 2'b00);
      checkOutput({tag, ".busy"}, busy, 1'b0);
   endtask

   task automatic genFrame(output byteQ_t f);
      logic [7:0] b;
      logic [7:0] chk;
      int         t;
      int         len;
      f = {};
      repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h3C;
         f.push_back(b);
      end
      f.push_back(8'hA5);
      t = $urandom_range(0, 9);
      if (t < 2) begin
         len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
         f.push_back(8'(len));
      end else begin
         len = $urandom_range(1, MAX_LEN);
         chk = 8'(len);
         f.push_back(chk);
         repeat (len) begin
            b = 8'($urandom);
            chk = chk ^ b;
            f.push_back(b);
         end
         if (t < 4) chk = chk ^ (8'h01 << $urandom_range(0, 7));
         f.push_back(chk);
      end
   endtask

   initial begin
      byteQ_t f;
      int     waited;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkResetValues("reset");
      arstN  = 1'b1;
      @(negedge clk);
      ctrlEn = 1'b1;
      #1;
      checkOutput("rxEnable.latency", rxEnable, 1'b0);
      @(negedge clk);
      checkOutput("rxEnable.on", rxEnable, 1'b1);
      @(negedge clk);

      // Good frame
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      sendFrame(f);
      checkFrame("good3", f);

      // Bad checksum followed by a good frame
      f = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
      sendFrame(f);
      checkFrame("badchk", f);
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      sendFrame(f);
      checkFrame("afterbad", f);

      // Illegal lengths, with leading garbage
      f = '{8'h3C, 8'h7E, 8'hA5, 8'h00};
      sendFrame(f);
      checkFrame("len0", f);
      f = '{8'hA5, 8'h11};
      sendFrame(f);
      checkFrame("len17", f);

      // Full-length frame with SYNC values inside the payload
      f = '{8'hA5, 8'h10};
      for (int i = 0; i < MAX_LEN; i++) f.push_back((i % 3 == 0) ? 8'hA5 : 8'(i * 7));
      begin
         logic [7:0] c;
         c = 8'h10;
         for (int i = 2; i < f.size(); i++) c = c ^ f[i];
         f.push_back(c);
      end
      sendFrame(f);
      checkFrame("len16", f);

      // Timeout: error pulse exactly TMO clocks after the last rx_done
      f = '{8'hA5, 8'h04, 8'h01};
      sendFrame(f);
      waited = 0;
      while (errCodeQ.size() == 0 && waited < TMO + 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkOutput("tmo.seen", errCodeQ.size(), 1);
      checkOutput("tmo.code", (errCodeQ.size() > 0) ? errCodeQ[0] : -1, 3);
      checkOutput("tmo.delay", (errCycQ.size() > 0) ? (errCycQ[0] - lastDrv - 1) : -1, TMO);
      checkOutput("tmo.nwrites", wrDataQ.size(), 1);
      checkOutput("tmo.nvalid", valLenQ.size(), 0);
      repeat (3) @(negedge clk);
      clearSb();

      // Baud update accepted while waiting for SYNC, ignored mid-frame
      @(negedge clk);
      cfgBaudSel = 4'b0101;
      cfgLoad    = 1'b1;
      @(negedge clk);
      cfgLoad    = 1'b0;
      checkOutput("baud.waitSync", baudSel, 4'b0101);
      f = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h02 ^ 8'h5A ^ 8'hC3};
      applyStimulus(f[0]);
      applyStimulus(f[1]);
      applyStimulus(f[2]);
      cfgBaudSel = 4'b1010;
      cfgLoad    = 1'b1;
      @(negedge clk);
      cfgLoad    = 1'b0;
      @(negedge clk);
      checkOutput("baud.midFrame", baudSel, 4'b0101);
      applyStimulus(f[3]);
      applyStimulus(f[4]);
      checkFrame("baudFrame", f);

      // Asynchronous reset mid-payload
      applyStimulus(8'hA5);
      applyStimulus(8'h05);
      applyStimulus(8'h77);
      @(negedge clk);
      arstN = 1'b0;
      #1;
      checkResetValues("midReset");
      @(negedge clk);
      arstN = 1'b1;
      repeat (2) @(negedge clk);
      clearSb();
      f = '{8'hA5, 8'h01, 8'h9C, 8'h01 ^ 8'h9C};
      sendFrame(f);
      checkFrame("postReset", f);

      // Enable dropped mid-frame: silent abort
      applyStimulus(8'hA5);
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      ctrlEn = 1'b0;
      #1;
      checkOutput("ctrlDrop.rxEnableLag", rxEnable, 1'b1);
      @(negedge clk);
      checkOutput("ctrlDrop.rxEnable", rxEnable, 1'b0);
      checkOutput("ctrlDrop.busy", busy, 1'b0);
      repeat (TMO + 10) @(negedge clk);
      #1;
      checkOutput("ctrlDrop.nerror", errCodeQ.size(), 0);
      checkOutput("ctrlDrop.nvalid", valLenQ.size(), 0);
      checkOutput("ctrlDrop.nwrites", wrDataQ.size(), 1);
      clearSb();
      ctrlEn = 1'b1;
      repeat (2) @(negedge clk);
      f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      sendFrame(f);
      checkFrame("reEnable", f);

      // Random frames against the model
      for (int n = 0; n < 12; n++) begin
         genFrame(f);
         sendFrame(f);
         checkFrame("random", f);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the UART receive path: enables the baud-rate generator/receiver pair, owns their baud selection, and parses the received byte stream into framed packets.
- Frame format: SYNC byte, LEN byte, LEN payload bytes, CHK byte.
- Payload bytes are written to a local buffer memory as they arrive. Frame completion or failure is reported to the processor side by a one-cycle pulse.

Parameters:
- DATA_WIDTH, 8, receiver byte width
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_LEN, 16, maximum payload length; LEN of 0 or >MAX_LEN is illegal
- ADDR_WIDTH, 4, buffer address width; must satisfy 2**ADDR_WIDTH >= MAX_LEN
- TIMEOUT_CYCLES, 2_000_000, clocks allowed between bytes inside a frame

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- ctrl_en  input  1  controller enable; drives rx_enable
- cfg_baud_sel  input  4  requested baud selection
- cfg_load  input  1  pulse; request baud_sel update
- rx_done  input  1  receiver one-cycle byte-valid strobe
- rx_data  input  DATA_WIDTH  receiver byte
- rx_enable  output  1  enable to baud generator and receiver
- baud_sel  output  4  baud selection to baud generator
- mem_we  output  1  buffer write strobe
- mem_addr  output  ADDR_WIDTH  buffer write address (payload index)
- mem_wdata  output  DATA_WIDTH  buffer write data
- pkt_valid  output  1  one-cycle pulse: frame accepted
- pkt_len  output  ADDR_WIDTH+1  length of last accepted frame, held until the next accept
- pkt_error  output  1  one-cycle pulse: frame rejected
- err_code  output  2  01 bad LEN, 10 checksum mismatch, 11 timeout; held until the next error
- busy  output  1  high while a frame is in progress (GET_LEN, GET_DATA, GET_CHK)

Behaviour:
- Reset values:
  - baud_sel = 4'b0011; all other outputs 0.
  - FSM in IDLE; internal counters and checksum cleared.
- rx_enable = ctrl_en (registered, 1-cycle latency).
- ctrl_en low in any state: return to IDLE next cycle; any partial frame is discarded with no pkt_error and no further writes.
- Baud update: on cfg_load, baud_sel <= cfg_baud_sel next cycle, but only in IDLE or WAIT_SYNC. cfg_load during a frame is ignored and is not queued.
- FSM states and transitions:
  - IDLE: ctrl_en=1 -> WAIT_SYNC.
  - WAIT_SYNC: rx_done with rx_data==SYNC_BYTE -> GET_LEN. Other bytes are silently dropped.
  - GET_LEN: on rx_done:
    - LEN in 1..MAX_LEN: latch len, clear checksum to 0, then chk ^= LEN, idx=0 -> GET_DATA.
    - Otherwise -> ERROR with code 01.
  - GET_DATA: on rx_done: mem_we=1, mem_addr=idx, mem_wdata=rx_data on the next cycle; chk ^= rx_data; idx++. When idx reaches len -> GET_CHK.
  - GET_CHK: on rx_done: rx_data==chk -> DONE; else -> ERROR with code 10.
  - DONE: pkt_valid=1 and pkt_len=len for one cycle -> WAIT_SYNC.
  - ERROR: pkt_error=1 and err_code set for one cycle -> WAIT_SYNC.
- Write latency: mem_we asserts exactly 1 cycle after the rx_done that carried the byte; one write per payload byte; never written for SYNC, LEN or CHK.
- Timeout:
  - Counter resets on every rx_done and on entry to GET_LEN.
  - Counts only in GET_LEN, GET_DATA and GET_CHK.
  - Reaching TIMEOUT_CYCLES -> ERROR with code 11.
  - If rx_done and timeout occur in the same cycle, rx_done wins.
- A SYNC_BYTE value inside a frame is treated as ordinary data/LEN/CHK (no resync).
- Buffer contents written by a rejected frame remain; the consumer uses only pkt_valid/pkt_len.
- rx_done arriving in DONE or ERROR is dropped. The receiver cannot produce back-to-back bytes that close.
- arst_n low at any time: immediate return to reset values, including mid-frame.

Test Plan:
1. Frame A5,03,11,22,33,CHK=03^11^22^33=03 -> writes (0,11),(1,22),(2,33), each 1 cycle after its rx_done; pkt_valid pulse; pkt_len=3; busy low afterwards.
2. Frame A5,02,AA,55,CHK=00 (correct value FD) -> two writes, then pkt_error with err_code=10; no pkt_valid; next frame is accepted normally.
3. A5,00 and A5,11 (MAX_LEN=16) -> pkt_error with err_code=01 each time, no writes; garbage 3C,7E before A5 is silently dropped.
4. A5,04,01 then silence, with TIMEOUT_CYCLES=100 -> pkt_error with err_code=11 exactly 100 clocks after the last rx_done.
5. cfg_load with cfg_baud_sel=0101 in WAIT_SYNC -> baud_sel=0101 next cycle. The same request in GET_DATA -> baud_sel unchanged.
6. arst_n pulsed low mid-payload -> all outputs at reset values and baud_sel=0011 immediately; a fresh frame after release is accepted. ctrl_en dropped mid-frame -> IDLE, no pkt_error, rx_enable=0 one cycle later.
